// File: rtl/mips_cpu_regs_dumper.sv
// Debug reader for the CPU register file: walks registers FIRST_REG..LAST_REG two at a time
// through both read ports and streams (index, data) beats over a valid/ready handshake.
module mips_cpu_regs_dumper #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  read_reg_1,
    output logic [4:0]  read_reg_2,
    input  logic [31:0] read_data_1,
    input  logic [31:0] read_data_2,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [4:0]  dump_index,
    output logic [31:0] dump_data
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EMIT0,
        EMIT1,
        DONE
    } state_t;

    localparam logic [5:0] FIRST6 = 6'(FIRST_REG);
    localparam logic [5:0] LAST6  = 6'(LAST_REG);

    state_t      state;
    state_t      state_nx;
    // Six bits so idx+1 / idx+2 at the top of the file never alias back to register 0.
    logic [5:0]  idx;
    logic [31:0] buf0;
    logic [31:0] buf1;
    logic [1:0]  pair_cnt;

    logic [5:0]  idx_p1;
    logic        has_pair;
    logic [4:0]  reg2_sel;
    logic        last_pair;
    logic        advance;

    assign idx_p1    = idx + 6'd1;
    assign has_pair  = (idx_p1 <= LAST6);
    assign reg2_sel  = has_pair ? idx_p1[4:0] : idx[4:0];
    assign last_pair = ({1'b0, idx} + {5'b0, pair_cnt}) > 7'(LAST_REG);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    // NOTE: the capture buffers are reset too, so dump_data is deterministic out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= FIRST6;
            buf0     <= 32'd0;
            buf1     <= 32'd0;
            pair_cnt <= 2'd0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start) idx <= FIRST6;
                end
                FETCH: begin
                    buf0     <= read_data_1;
                    buf1     <= read_data_2;
                    pair_cnt <= has_pair ? 2'd2 : 2'd1;
                end
                default: begin
                    if (advance && !last_pair) idx <= idx + 6'd2;
                end
            endcase
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx   = state;
        busy       = 1'b0;
        done       = 1'b0;
        dump_valid = 1'b0;
        dump_index = 5'd0;
        dump_data  = 32'd0;
        read_reg_1 = 5'd0;
        read_reg_2 = 5'd0;
        advance    = 1'b0;

        case (state)
            IDLE: begin
                if (start) state_nx = FETCH;
            end
            FETCH: begin
                busy       = 1'b1;
                read_reg_1 = idx[4:0];
                read_reg_2 = reg2_sel;
                state_nx   = EMIT0;
            end
            EMIT0: begin
                busy       = 1'b1;
                read_reg_1 = idx[4:0];
                read_reg_2 = reg2_sel;
                dump_valid = 1'b1;
                dump_index = idx[4:0];
                dump_data  = buf0;
                if (dump_ready) begin
                    if (pair_cnt == 2'd2) state_nx = EMIT1;
                    else                  advance  = 1'b1;
                end
            end
            EMIT1: begin
                busy       = 1'b1;
                read_reg_1 = idx[4:0];
                read_reg_2 = reg2_sel;
                dump_valid = 1'b1;
                dump_index = idx_p1[4:0];
                dump_data  = buf1;
                if (dump_ready) advance = 1'b1;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        if (advance) state_nx = last_pair ? DONE : FETCH;
    end

endmodule

// File: tb/tb_mips_cpu_regs_dumper.sv
// Directed bench for mips_cpu_regs_dumper: full dumps, backpressure, sub-range, ignored
// starts, asynchronous reset abort and snapshot timing, against a behavioural register file.
module tb_mips_cpu_regs_dumper;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // full-range instance
    logic        start, busy, done, dump_valid, dump_ready;
    logic [4:0]  read_reg_1, read_reg_2, dump_index;
    logic [31:0] read_data_1, read_data_2, dump_data;
    // sub-range instance (3..7)
    logic        start_p, busy_p, done_p, dump_valid_p, dump_ready_p;
    logic [4:0]  read_reg_1_p, read_reg_2_p, dump_index_p;
    logic [31:0] read_data_1_p, read_data_2_p, dump_data_p;

    logic [31:0] rf     [32];
    logic [31:0] rf_p   [32];
    logic [31:0] exp_rf [32];

    assign read_data_1   = rf[read_reg_1];
    assign read_data_2   = rf[read_reg_2];
    assign read_data_1_p = rf_p[read_reg_1_p];
    assign read_data_2_p = rf_p[read_reg_2_p];

    mips_cpu_regs_dumper dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
        .read_data_1(read_data_1), .read_data_2(read_data_2),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_index(dump_index), .dump_data(dump_data)
    );

    mips_cpu_regs_dumper #(.FIRST_REG(3), .LAST_REG(7)) dut_p (
        .clk(clk), .reset(reset), .start(start_p), .busy(busy_p), .done(done_p),
        .read_reg_1(read_reg_1_p), .read_reg_2(read_reg_2_p),
        .read_data_1(read_data_1_p), .read_data_2(read_data_2_p),
        .dump_valid(dump_valid_p), .dump_ready(dump_ready_p),
        .dump_index(dump_index_p), .dump_data(dump_data_p)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [4:0]  b_idx  [64];
    logic [31:0] b_data [64];
    int          nbeats, ndone, done_cycle, stable_err;
    logic [4:0]  last_rr1, last_rr2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pulses start on the selected instance and collects beats until a few cycles past done.
    task automatic run_dump(input bit sel, input bit bp, input bit poke, input bit late_write);
        logic        v, b, dn, r, hold_v;
        logic [4:0]  i, r1, r2, hi;
        logic [31:0] d, hd;
        bit          do_write;
        nbeats = 0; ndone = 0; done_cycle = -1; stable_err = 0;
        hold_v = 1'b0; hi = 5'd0; hd = 32'd0; do_write = 1'b0;
        @(negedge clk);
        if (sel) start_p = 1'b1; else start = 1'b1;
        @(negedge clk);
        start = 1'b0; start_p = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (c > 0) @(negedge clk);
            if (do_write) begin
                rf[2]    = 32'hDEADBEEF;
                do_write = 1'b0;
            end
            #1;
            v  = sel ? dump_valid_p : dump_valid;
            b  = sel ? busy_p       : busy;
            dn = sel ? done_p       : done;
            i  = sel ? dump_index_p : dump_index;
            d  = sel ? dump_data_p  : dump_data;
            r1 = sel ? read_reg_1_p : read_reg_1;
            r2 = sel ? read_reg_2_p : read_reg_2;
            if (c == 0) check("busy_in_first_fetch", {31'd0, b}, 32'd1);
            if (hold_v && !(v && i == hi && d == hd)) stable_err++;
            if (b && !v) begin
                last_rr1 = r1;
                last_rr2 = r2;
                if (late_write && r1 == 5'd2) do_write = 1'b1;
            end
            if (dn) begin
                ndone++;
                if (done_cycle < 0) done_cycle = c;
            end
            r = bp ? ((c % 4) == 0 || (c % 4) == 3) : 1'b1;
            if (sel) dump_ready_p = r; else dump_ready = r;
            start = !sel && poke && ((v && i == 5'd10) || dn);
            if (v && r && nbeats < 64) begin
                b_idx[nbeats]  = i;
                b_data[nbeats] = d;
                nbeats++;
            end
            hold_v = v && !r;
            hi = i;
            hd = d;
            if (done_cycle >= 0 && c >= done_cycle + 4) break;
        end
        start = 1'b0;
        dump_ready = 1'b1;
        dump_ready_p = 1'b1;
    endtask

    task automatic check_beats(input string tag, input bit sel, input int first, input int last);
        check({tag, "_beat_count"}, nbeats, last - first + 1);
        check({tag, "_done_count"}, ndone, 1);
        check({tag, "_held_stable"}, stable_err, 0);
        for (int k = 0; k < nbeats && k <= last - first; k++) begin
            check($sformatf("%s_beat%0d_index", tag, k), {27'd0, b_idx[k]}, first + k);
            check($sformatf("%s_beat%0d_data", tag, k), b_data[k],
                  sel ? 32'((first + k) * 17) : exp_rf[first + k]);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0; start_p = 1'b0;
        dump_ready = 1'b1; dump_ready_p = 1'b1;
        for (int k = 0; k < 32; k++) begin
            rf[k]     = 32'd0;
            exp_rf[k] = 32'd0;
            rf_p[k]   = 32'(k * 17);
        end
        rf[5] = 32'h00008000; exp_rf[5] = 32'h00008000;
        rf[6] = 32'h000a0000; exp_rf[6] = 32'h000a0000;

        #12;
        check("rst_busy",  {31'd0, busy},       32'd0);
        check("rst_done",  {31'd0, done},       32'd0);
        check("rst_valid", {31'd0, dump_valid}, 32'd0);
        check("rst_index", {27'd0, dump_index}, 32'd0);
        check("rst_data",  dump_data,           32'd0);
        check("rst_rr1",   {27'd0, read_reg_1}, 32'd0);
        check("rst_rr2",   {27'd0, read_reg_2}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // 1: full dump, ready held high
        run_dump(1'b0, 1'b0, 1'b0, 1'b0);
        check_beats("t1", 1'b0, 0, 31);
        check("t1_fetch_to_done_cycles", done_cycle, 48);
        check("t1_last_rr1", {27'd0, last_rr1}, 30);
        check("t1_last_rr2", {27'd0, last_rr2}, 31);

        // 2: backpressure 1,0,0,1
        run_dump(1'b0, 1'b1, 1'b0, 1'b0);
        check_beats("t2", 1'b0, 0, 31);

        // 3: sub-range 3..7
        run_dump(1'b1, 1'b0, 1'b0, 1'b0);
        check_beats("t3", 1'b1, 3, 7);
        check("t3_fetch_to_done_cycles", done_cycle, 8);
        check("t3_last_rr1", {27'd0, last_rr1_p()}, 7);
        check("t3_last_rr2", {27'd0, last_rr2}, 7);

        // 4: start during beat 10 and during DONE is ignored
        run_dump(1'b0, 1'b0, 1'b1, 1'b0);
        check_beats("t4", 1'b0, 0, 31);
        check("t4_idle_busy",  {31'd0, busy},       32'd0);
        check("t4_idle_valid", {31'd0, dump_valid}, 32'd0);
        run_dump(1'b0, 1'b0, 1'b0, 1'b0);
        check_beats("t4_fresh", 1'b0, 0, 31);

        // 5: asynchronous reset during EMIT1 of pair (8,9)
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            bit reached;
            reached = 1'b0;
            for (int c = 0; c < 100 && !reached; c++) begin
                #1;
                if (dump_valid && dump_index == 5'd9) reached = 1'b1;
                else @(negedge clk);
            end
            check("t5_reached_beat9", {31'd0, reached}, 32'd1);
        end
        #2 reset = 1'b1;
        #1;
        check("t5_async_valid", {31'd0, dump_valid}, 32'd0);
        check("t5_async_busy",  {31'd0, busy},       32'd0);
        check("t5_async_rr1",   {27'd0, read_reg_1}, 32'd0);
        check("t5_async_rr2",   {27'd0, read_reg_2}, 32'd0);
        check("t5_async_index", {27'd0, dump_index}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("t5_no_done_in_reset", {31'd0, done}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("t5_no_done_after", {31'd0, done}, 32'd0);
        run_dump(1'b0, 1'b0, 1'b0, 1'b0);
        check_beats("t5", 1'b0, 0, 31);

        // 6: write after the (2,3) fetch is not seen; write before it is
        run_dump(1'b0, 1'b0, 1'b0, 1'b1);
        check_beats("t6_late", 1'b0, 0, 31);
        exp_rf[2] = 32'hDEADBEEF;
        run_dump(1'b0, 1'b0, 1'b0, 1'b0);
        check_beats("t6_early", 1'b0, 0, 31);
        rf[2] = 32'd0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    function automatic logic [4:0] last_rr1_p();
        return last_rr1;
    endfunction

endmodule
